// File: rtl/fir_mac_sched_if.sv
// Sample, coefficient-write and filtered-output signals of the shared-MAC FIR controller.
// The master drives samples and coefficient writes; the slave is the filter itself.
interface fir_mac_sched_if;
  logic               en;
  logic [9:0]         din;
  logic [4:0]         num_taps;
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic signed [11:0] coef_wdata;
  logic               coef_ready;
  logic               sample_tick;
  logic               busy;
  logic [9:0]         dout;
  logic               dout_valid;

  modport master (
    output en, din, num_taps, coef_we, coef_addr, coef_wdata,
    input  coef_ready, sample_tick, busy, dout, dout_valid
  );

  modport slave (
    input  en, din, num_taps, coef_we, coef_addr, coef_wdata,
    output coef_ready, sample_tick, busy, dout, dout_valid
  );
endinterface

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR: one multiply-accumulate walks the taps one per clock after
// each sample strobe, then the accumulator is scaled and saturated to a 10-bit output.
module fir_mac_sched #(
  parameter int DIV      = 500,
  parameter int MAX_TAPS = 21,
  parameter int SHIFT    = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  fir_mac_sched_if.slave  bus
);
  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, MAC, SCALE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [4:0]         idx_reg, idx_next;
  logic [4:0]         n_reg, n_next;
  logic signed [31:0] acc_reg, acc_next;
  logic [9:0]         dout_reg;
  logic               dout_valid_reg;
  logic [9:0]         x_reg [MAX_TAPS];
  logic signed [11:0] c_reg [MAX_TAPS];

  logic               tick;
  logic               shift_en;
  logic               coef_write;
  logic               load_dout;
  logic [9:0]         x_sel;
  logic signed [11:0] c_sel;
  logic signed [10:0] x_ext;
  logic signed [22:0] prod;
  logic signed [31:0] scaled;
  logic [9:0]         sat;

  function automatic logic signed [11:0] coef_default(input int k);
    case (k)
      0, 7:    coef_default = 12'sd9;
      1, 6:    coef_default = 12'sd49;
      2, 5:    coef_default = 12'sd168;
      3, 4:    coef_default = 12'sd286;
      default: coef_default = 12'sd0;
    endcase
  endfunction

  assign tick       = bus.en && (count_reg == CW'(DIV - 1));
  assign shift_en   = (state_reg == IDLE) && tick;
  // The bank is frozen from the strobe until the sequence returns to IDLE.
  assign coef_write = bus.coef_we && bus.coef_ready;

  assign bus.sample_tick = tick;
  assign bus.coef_ready  = (state_reg == IDLE) && !tick;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.dout        = dout_reg;
  assign bus.dout_valid  = dout_valid_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (!bus.en || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_TAPS; gi++) begin : g_tap
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          c_reg[gi] <= coef_default(gi);
        end else if (coef_write && (bus.coef_addr == 5'(gi))) begin
          c_reg[gi] <= bus.coef_wdata;
        end
      end

      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            x_reg[gi] <= '0;
          end else if (shift_en) begin
            x_reg[gi] <= bus.din;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (!reset_n) begin
            x_reg[gi] <= '0;
          end else if (shift_en) begin
            x_reg[gi] <= x_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign x_sel = x_reg[idx_reg];
  assign c_sel = c_reg[idx_reg];
  assign x_ext = $signed({1'b0, x_sel});
  assign prod  = x_ext * c_sel;

  assign scaled = acc_reg >>> SHIFT;
  always_comb begin
    sat = scaled[9:0];
    if (scaled < 32'sd0) begin
      sat = 10'd0;
    end else if (scaled > 32'sd1023) begin
      sat = 10'd1023;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      n_reg          <= 5'd1;
      acc_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      n_reg          <= n_next;
      acc_reg        <= acc_next;
      dout_valid_reg <= load_dout;
      if (load_dout) begin
        dout_reg <= sat;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    n_next     = n_reg;
    acc_next   = acc_reg;
    load_dout  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick) begin
          if (bus.num_taps == 5'd0) begin
            n_next = 5'd1;
          end else if (bus.num_taps > 5'(MAX_TAPS)) begin
            n_next = 5'(MAX_TAPS);
          end else begin
            n_next = bus.num_taps;
          end
          acc_next   = '0;
          idx_next   = '0;
          state_next = MAC;
        end
      end
      MAC: begin
        acc_next = acc_reg + {{9{prod[22]}}, prod};
        idx_next = idx_reg + 5'd1;
        if (idx_reg == n_reg - 5'd1) begin
          state_next = SCALE;
        end
      end
      SCALE: begin
        load_dout  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed checks of the shared-MAC FIR controller: DC settling, impulse response,
// coefficient handshake, saturation, latency/clamping and mid-sequence reset.
module tb_fir_mac_sched;
  localparam int DIV = 500;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  fir_mac_sched_if bus ();

  fir_mac_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    bus.en = 1'b0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_wdata = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_tick(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.sample_tick && n < DIV + 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.sample_tick;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL tick_timeout: got no sample_tick required one within %0d cycles", DIV + 20);
    end
  endtask

  task automatic run_tick(input logic [9:0] d, output logic [9:0] q, output int vcyc);
    bit ok;
    int n = 0;
    wait_tick(ok);
    bus.din = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.dout_valid && n < 100);
    if (!bus.dout_valid) begin
      n_cmp++; n_err++;
      $display("FAIL valid_timeout: got no dout_valid required one within 100 cycles");
    end
    q = bus.dout;
    vcyc = cyc;
  endtask

  task automatic write_coef(input logic [4:0] a, input logic signed [11:0] d, output int waited);
    int n = 0;
    bus.coef_we = 1'b1;
    bus.coef_addr = a;
    bus.coef_wdata = d;
    while (!bus.coef_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic test_reset();
    int ticks = 0;
    bus.din = '0;
    bus.num_taps = 5'd8;
    bus.en = 1'b0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_wdata = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.dout !== 10'd0) begin n_err++; $display("FAIL rst_dout: got %0d expected 0", bus.dout); end
    n_cmp++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", bus.dout_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.sample_tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b expected 0", bus.sample_tick); end
    n_cmp++; if (bus.coef_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", bus.coef_ready); end
    reset_n = 1'b1;
    for (int i = 0; i < DIV + 100; i++) begin
      @(negedge clk);
      if (bus.sample_tick) ticks++;
    end
    n_cmp++; if (ticks !== 0) begin n_err++; $display("FAIL en_low_ticks: got %0d expected 0", ticks); end
    $display("test_reset done");
  endtask

  task automatic test_dc();
    int exp_q[9] = '{4, 29, 113, 256, 399, 483, 507, 512, 512};
    logic [9:0] q;
    int vc, prev = 0;
    do_reset();
    bus.num_taps = 5'd8;
    bus.din = 10'd512;
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_tick(10'd512, q, vc);
      n_cmp++;
      if (q !== 10'(exp_q[i])) begin n_err++; $display("FAIL dc_out[%0d]: got %0d expected %0d", i, q, exp_q[i]); end
      if (i > 0) begin
        n_cmp++;
        if (vc - prev !== DIV) begin n_err++; $display("FAIL dc_period[%0d]: got %0d expected %0d", i, vc - prev, DIV); end
      end
      prev = vc;
      $display("dc tick %0d: dout=%0d", i, q);
    end
  endtask

  task automatic test_impulse();
    int exp_q[9] = '{8, 47, 164, 279, 279, 164, 47, 8, 0};
    logic [9:0] q;
    int vc;
    do_reset();
    bus.num_taps = 5'd8;
    bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_tick((i == 0) ? 10'd1000 : 10'd0, q, vc);
      n_cmp++;
      if (q !== 10'(exp_q[i])) begin n_err++; $display("FAIL impulse[%0d]: got %0d expected %0d", i, q, exp_q[i]); end
      $display("impulse tick %0d: dout=%0d", i, q);
    end
  endtask

  task automatic test_coef_port();
    bit ok;
    int n = 0, w, vc;
    logic [9:0] q;
    do_reset();
    bus.num_taps = 5'd1;
    bus.en = 1'b1;
    wait_tick(ok);
    bus.din = 10'd600;
    bus.coef_we = 1'b1;
    bus.coef_addr = 5'd0;
    bus.coef_wdata = 12'sd1024;
    n_cmp++; if (bus.coef_ready !== 1'b0) begin n_err++; $display("FAIL ready_at_tick: got %b expected 0", bus.coef_ready); end
    while (!bus.coef_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL ready_wait: got %0d expected 3", n); end
    n_cmp++; if (bus.dout_valid !== 1'b1 || bus.dout !== 10'd5) begin
      n_err++; $display("FAIL inflight_coef: got valid=%b dout=%0d expected valid=1 dout=5", bus.dout_valid, bus.dout);
    end
    @(negedge clk);
    bus.coef_we = 1'b0;
    $display("coef write c0=1024 accepted after %0d cycles", n);
    run_tick(10'd700, q, vc);
    n_cmp++; if (q !== 10'd700) begin n_err++; $display("FAIL passthru_700: got %0d expected 700", q); end
    run_tick(10'd300, q, vc);
    n_cmp++; if (q !== 10'd300) begin n_err++; $display("FAIL passthru_300: got %0d expected 300", q); end
    write_coef(5'd25, 12'sd1, w);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL addr25_ack: got wait %0d expected 0", w); end
    run_tick(10'd123, q, vc);
    n_cmp++; if (q !== 10'd123) begin n_err++; $display("FAIL addr25_nochange: got %0d expected 123", q); end
    $display("coef port: pass-through and out-of-range write done");
  endtask

  task automatic test_saturation();
    int w, vc;
    logic [9:0] q;
    write_coef(5'd0, 12'sd2047, w);
    run_tick(10'd1023, q, vc);
    n_cmp++; if (q !== 10'd1023) begin n_err++; $display("FAIL sat_high: got %0d expected 1023", q); end
    $display("sat c0=2047 din=1023: dout=%0d", q);
    run_tick(10'd500, q, vc);
    n_cmp++; if (q !== 10'd999) begin n_err++; $display("FAIL sat_below: got %0d expected 999", q); end
    $display("sat c0=2047 din=500: dout=%0d", q);
    write_coef(5'd0, -12'sd100, w);
    run_tick(10'd1023, q, vc);
    n_cmp++; if (q !== 10'd0) begin n_err++; $display("FAIL sat_low: got %0d expected 0", q); end
    $display("sat c0=-100 din=1023: dout=%0d", q);
  endtask

  task automatic measure(input logic [4:0] nt, input int exp_busy, input int exp_lat, input string name);
    bit ok;
    int busy_cnt = 0, lat = 0;
    bus.num_taps = nt;
    wait_tick(ok);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.dout_valid && lat == 0) lat = k;
    end
    n_cmp++; if (busy_cnt !== exp_busy) begin n_err++; $display("FAIL %s_busy: got %0d expected %0d", name, busy_cnt, exp_busy); end
    n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    $display("%s: busy=%0d latency=%0d", name, busy_cnt, lat);
  endtask

  task automatic test_latency();
    do_reset();
    bus.din = 10'd100;
    bus.en = 1'b1;
    measure(5'd21, 22, 23, "taps21");
    measure(5'd31, 22, 23, "taps31");
    measure(5'd0, 2, 3, "taps0");
  endtask

  task automatic test_midreset();
    bit ok;
    int w, vc, pulses = 0;
    logic [9:0] q;
    do_reset();
    bus.num_taps = 5'd8;
    bus.en = 1'b1;
    write_coef(5'd0, 12'sd1024, w);
    run_tick(10'd512, q, vc);
    n_cmp++; if (q !== 10'd512) begin n_err++; $display("FAIL pre_reset_out: got %0d expected 512", q); end
    wait_tick(ok);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.dout !== 10'd0 || bus.dout_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_state: got busy=%b dout=%0d valid=%b expected 0 0 0", bus.busy, bus.dout, bus.dout_valid);
    end
    n_cmp++; if (bus.coef_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b expected 1", bus.coef_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.dout_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_pulse: got %0d expected 0", pulses); end
    for (int i = 0; i < 8; i++) begin
      run_tick(10'd512, q, vc);
      if (i == 0) begin
        n_cmp++; if (q !== 10'd4) begin n_err++; $display("FAIL midrst_defaults: got %0d expected 4", q); end
      end
      $display("post-reset dc tick %0d: dout=%0d", i, q);
    end
    n_cmp++; if (q !== 10'd512) begin n_err++; $display("FAIL midrst_settle: got %0d expected 512", q); end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_impulse();
    test_coef_port();
    test_saturation();
    test_latency();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
